fetch_ctrl: RTL

Instruction-fetch controller for the RISC-V core. It owns the program counter, sequences requests on the instruction bus and arbitrates the next-PC source among trap, jump, stall, halt and sequential +4. It delivers fetched instructions to the IF/ID stage. It buffers one response across a pipeline stall and discards responses made stale by a redirect.

---
 rtl/fetch_ctrl_pkg.sv | 22 ++
 rtl/fetch_skid.sv | 40 ++++
 rtl/fetch_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package fetch_ctrl_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] CpuResetAddr = 32'h0000_0000;
    localparam logic [XLEN-1:0] InstNop      = 32'h0000_0013;
    localparam logic [XLEN-1:0] PcStep       = 32'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_KILL = 2'b10,
        S_HALT = 2'b11
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] addr;
    } fetch_word_t;

endpackage

// File: rtl/fetch_skid.sv
// One-entry holding buffer for a fetched word that arrives while IF/ID is stalled.
module fetch_skid
    import fetch_ctrl_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            load,
    input  logic            drain,
    input  logic            clear,
    input  logic [XLEN-1:0] d_inst,
    input  logic [XLEN-1:0] d_addr,
    output logic            full,
    output logic [XLEN-1:0] q_inst,
    output logic [XLEN-1:0] q_addr
);

    fetch_word_t word_q;
    logic        full_q;

    // Clear beats load: a redirect makes any captured word stale.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            full_q <= 1'b0;
            word_q <= '0;
        end else if (clear) begin
            full_q <= 1'b0;
        end else if (load) begin
            full_q      <= 1'b1;
            word_q.inst <= d_inst;
            word_q.addr <= d_addr;
        end else if (drain) begin
            full_q <= 1'b0;
        end
    end

    assign full   = full_q;
    assign q_inst = word_q.inst;
    assign q_addr = word_q.addr;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: PC ownership, ibus sequencing, next-PC arbitration
// and delivery of fetched words to IF/ID.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_ADDR = CpuResetAddr,
    parameter logic [XLEN-1:0] INST_NOP   = InstNop
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            stall_i,
    input  logic            halt_i,
    input  logic            jump_flag_i,
    input  logic [XLEN-1:0] jump_addr_i,
    input  logic            trap_flag_i,
    input  logic [XLEN-1:0] trap_addr_i,
    output logic            ibus_req_o,
    output logic [XLEN-1:0] ibus_addr_o,
    input  logic            ibus_ack_i,
    input  logic [XLEN-1:0] ibus_rdata_i,
    output logic            ce_o,
    output logic            inst_valid_o,
    output logic [XLEN-1:0] inst_o,
    output logic [XLEN-1:0] inst_addr_o,
    output logic            flush_o,
    output logic            halted_o
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] hold_addr_q;
    logic            pend_q;
    logic            ce_q;
    logic            out_valid_q;
    logic [XLEN-1:0] out_inst_q;
    logic [XLEN-1:0] out_addr_q;

    logic            redirect;
    logic            take_redirect;
    logic [XLEN-1:0] target;
    logic            can_issue;
    logic            transfer;
    logic            run_xfer;
    logic            to_out;
    logic            skid_load;
    logic            skid_drain;
    logic            skid_full;
    logic [XLEN-1:0] skid_inst;
    logic [XLEN-1:0] skid_addr;

    // Next-PC arbitration: trap outranks jump; nothing is redirected out of reset.
    assign redirect      = trap_flag_i | jump_flag_i;
    assign target        = trap_flag_i ? trap_addr_i : jump_addr_i;
    assign take_redirect = redirect && (state_q != S_IDLE);

    assign can_issue   = (state_q == S_RUN) && !stall_i && !skid_full && !halt_i && !redirect;
    assign ibus_req_o  = ((state_q == S_RUN) || (state_q == S_KILL)) && (pend_q || can_issue);
    assign ibus_addr_o = pend_q ? hold_addr_q : pc_q;
    assign transfer    = ibus_req_o && ibus_ack_i;

    // Only data accepted in S_RUN without a concurrent redirect is architecturally live.
    assign run_xfer   = transfer && (state_q == S_RUN) && !take_redirect;
    assign to_out     = run_xfer && (!stall_i || !out_valid_q);
    assign skid_load  = run_xfer && stall_i && out_valid_q;
    assign skid_drain = !stall_i && skid_full && !take_redirect;

    fetch_skid u_skid (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load   (skid_load),
        .drain  (skid_drain),
        .clear  (take_redirect),
        .d_inst (ibus_rdata_i),
        .d_addr (ibus_addr_o),
        .full   (skid_full),
        .q_inst (skid_inst),
        .q_addr (skid_addr)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            S_IDLE: state_d = S_RUN;
            S_RUN: begin
                if (take_redirect) begin
                    pc_d = target;
                end else if (run_xfer) begin
                    pc_d = pc_q + PcStep;
                end
                if (take_redirect && pend_q && !ibus_ack_i) begin
                    state_d = S_KILL;
                end else if (halt_i && !pend_q) begin
                    state_d = S_HALT;
                end
            end
            S_KILL: begin
                if (take_redirect) begin
                    pc_d = target;
                end
                if (transfer) begin
                    state_d = S_RUN;
                end
            end
            S_HALT: begin
                if (take_redirect) begin
                    pc_d = target;
                end
                if (!halt_i) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_ADDR;
            hold_addr_q <= RESET_ADDR;
            pend_q      <= 1'b0;
            ce_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (state_q == S_IDLE) begin
                ce_q <= 1'b1;
            end
            // Latch the address on first presentation so it stays stable until ack.
            if (transfer) begin
                pend_q <= 1'b0;
            end else if (ibus_req_o) begin
                pend_q <= 1'b1;
                if (!pend_q) begin
                    hold_addr_q <= pc_q;
                end
            end
        end
    end

    // IF/ID output register: skid has priority so program order is kept.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            out_valid_q <= 1'b0;
            out_inst_q  <= INST_NOP;
            out_addr_q  <= '0;
        end else if (take_redirect) begin
            out_valid_q <= 1'b0;
        end else if (!stall_i && skid_full) begin
            out_valid_q <= 1'b1;
            out_inst_q  <= skid_inst;
            out_addr_q  <= skid_addr;
        end else if (to_out) begin
            out_valid_q <= 1'b1;
            out_inst_q  <= ibus_rdata_i;
            out_addr_q  <= ibus_addr_o;
        end else if (!stall_i) begin
            out_valid_q <= 1'b0;
        end
    end

    assign ce_o         = ce_q;
    assign inst_valid_o = out_valid_q;
    assign inst_o       = out_valid_q ? out_inst_q : INST_NOP;
    assign inst_addr_o  = out_addr_q;
    assign flush_o      = take_redirect;
    assign halted_o     = (state_q == S_HALT);

endmodule
